elevator_call_scheduler: RTL and testbench

- Latches floor-call buttons into a pending-call register.
- Chooses the next floor to serve with a collective up/down (SCAN) policy.
- Drives the requested floor into the elevator state machine and sequences a door-open dwell at each served floor.
- Sits between the call-button inputs and the elevator state machine; replaces the direct one-hot-to-floor decode.

---
 rtl/elevator_call_scheduler_if.sv | 18 +
 rtl/elevator_call_scheduler.sv | 118 +++++++++++
 tb/tb_elevator_call_scheduler.sv | 131 +++++++++++++
 3 files changed

// File: rtl/elevator_call_scheduler_if.sv
// elevator_call_scheduler_if: call buttons, car status and scheduler outputs between buttons, scheduler and car FSM
interface elevator_call_scheduler_if #(
  parameter int NUM_FLOORS = 9,
  parameter int FLOOR_W    = 4
);
  logic [NUM_FLOORS-1:0] call_req;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  car_idle;
  logic [FLOOR_W-1:0]    target_floor;
  logic [NUM_FLOORS-1:0] pending;
  logic                  dir_up;
  logic                  door_open;
  logic                  busy;
  modport master (output call_req, current_floor, car_idle,
                  input  target_floor, pending, dir_up, door_open, busy);
  modport slave  (input  call_req, current_floor, car_idle,
                  output target_floor, pending, dir_up, door_open, busy);
endinterface

// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler: latches floor calls and serves them with a SCAN policy plus door dwell
module elevator_call_scheduler #(
  parameter int          NUM_FLOORS  = 9,
  parameter int          FLOOR_W     = 4,
  parameter logic [23:0] DOOR_CYCLES = 24'd5000000
) (
  input logic clk,
  input logic rst,
  elevator_call_scheduler_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_DOOR} state_t;
  localparam logic [FLOOR_W:0] NF = NUM_FLOORS[FLOOR_W:0];
  state_t                state;
  logic [23:0]           cnt;
  logic [NUM_FLOORS-1:0] pend, cf_oh, tg_oh, call_m, eff, clr;
  logic [FLOOR_W-1:0]    tgt, cf, next_up, next_dn;
  logic                  dir_up, door, busy, above, below, cf_ok, at_tgt, arrive, go_up, reopen;
  assign bus.target_floor = tgt;
  assign bus.pending      = pend;
  assign bus.dir_up       = dir_up;
  assign bus.door_open    = door;
  assign bus.busy         = busy;
  always_comb begin
    cf      = bus.current_floor;
    cf_ok   = {1'b0, cf} < NF;
    cf_oh   = cf_ok ? {{(NUM_FLOORS-1){1'b0}}, 1'b1} << cf : '0;
    tg_oh   = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << tgt;
    call_m  = bus.call_req & ~(state == S_DOOR ? cf_oh : '0);
    eff     = pend | call_m;
    reopen  = |(bus.call_req & cf_oh);
    above   = 1'b0;
    below   = 1'b0;
    next_up = '0;
    next_dn = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (pend[i] && FLOOR_W'(i) > cf) begin
        above   = 1'b1;
        next_up = FLOOR_W'(i);
      end
    for (int i = 0; i < NUM_FLOORS; i++)
      if (pend[i] && FLOOR_W'(i) < cf) begin
        below   = 1'b1;
        next_dn = FLOOR_W'(i);
      end
    go_up  = above && (!below || (next_up - cf) <= (cf - next_dn));
    at_tgt = cf == tgt && |(pend & tg_oh);
    arrive = bus.car_idle && at_tgt;
    clr    = !cf_ok ? '0 :
             state == S_IDLE ? (eff & cf_oh) :
             (state == S_UP || state == S_DOWN) && arrive ? tg_oh : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pend   <= '0;
      tgt    <= '0;
      dir_up <= 1'b1;
      door   <= 1'b0;
      busy   <= 1'b0;
      cnt    <= '0;
    end else begin
      pend <= eff & ~clr;
      if (!cf_ok) begin
        state <= S_IDLE;
        tgt   <= '0;
        door  <= 1'b0;
        busy  <= 1'b0;
      end else case (state)
        S_IDLE:
          if (|(eff & cf_oh)) begin
            state <= S_DOOR;
            door  <= 1'b1;
            busy  <= 1'b1;
            cnt   <= DOOR_CYCLES - 24'd1;
            tgt   <= cf;
          end else if (above || below) begin
            state  <= go_up ? S_UP : S_DOWN;
            dir_up <= go_up;
            tgt    <= go_up ? next_up : next_dn;
            busy   <= 1'b1;
          end else tgt <= cf;
        S_UP, S_DOWN:
          if (arrive) begin
            state <= S_DOOR;
            door  <= 1'b1;
            cnt   <= DOOR_CYCLES - 24'd1;
          end else if (at_tgt) begin
          end else if (state == S_UP ? above : below) tgt <= state == S_UP ? next_up : next_dn;
          else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        S_DOOR: begin
          tgt <= cf;
          if (reopen) cnt <= DOOR_CYCLES - 24'd1;
          else if (cnt != '0) cnt <= cnt - 24'd1;
          else begin
            door <= 1'b0;
            // keep sweeping the same way while calls remain ahead, otherwise reverse or rest
            if (above && (dir_up || !below)) begin
              state  <= S_UP;
              dir_up <= 1'b1;
              tgt    <= next_up;
            end else if (below) begin
              state  <= S_DOWN;
              dir_up <= 1'b0;
              tgt    <= next_dn;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb_elevator_call_scheduler: directed SCAN scheduling scenarios with a short door dwell
module tb_elevator_call_scheduler;
  localparam int NF = 9;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int errs = 0;
  always #5 clk = ~clk;
  elevator_call_scheduler_if #(.NUM_FLOORS(NF), .FLOOR_W(4)) bus ();
  elevator_call_scheduler #(.NUM_FLOORS(NF), .FLOOR_W(4), .DOOR_CYCLES(24'd4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic exp_out(input string tag, input int tg, input int pd, input int dir, input int door, input int busy);
    chk({tag, ".target"}, int'(bus.target_floor), tg);
    chk({tag, ".pending"}, int'(bus.pending), pd);
    chk({tag, ".dir_up"}, int'(bus.dir_up), dir);
    chk({tag, ".door"}, int'(bus.door_open), door);
    chk({tag, ".busy"}, int'(bus.busy), busy);
  endtask
  task automatic dwell3(input string tag, input int tg, input int pd, input int dir);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_out(tag, tg, pd, dir, 1, 1);
    end
  endtask
  initial begin
    rst = 1'b1;
    bus.call_req = '0;
    bus.current_floor = 4'd0;
    bus.car_idle = 1'b1;
    tick(); exp_out("reset", 0, 0, 1, 0, 0);
    rst = 1'b0;
    bus.call_req = 9'h020;
    tick(); exp_out("t1_latch", 0, 'h020, 1, 0, 0);
    bus.call_req = '0;
    tick(); exp_out("t1_up", 5, 'h020, 1, 0, 1);
    bus.current_floor = 4'd5;
    tick(); exp_out("t1_arrive", 5, 0, 1, 1, 1);
    dwell3("t1_dwell", 5, 0, 1);
    tick(); exp_out("t1_idle", 5, 0, 1, 0, 0);
    bus.current_floor = 4'd2;
    tick(); exp_out("t2_hold", 2, 0, 1, 0, 0);
    bus.call_req = 9'h080;
    tick(); exp_out("t2_latch7", 2, 'h080, 1, 0, 0);
    bus.call_req = '0;
    tick(); exp_out("t2_up7", 7, 'h080, 1, 0, 1);
    bus.car_idle = 1'b0;
    bus.current_floor = 4'd3;
    bus.call_req = 9'h010;
    tick(); exp_out("t2_latch4", 7, 'h090, 1, 0, 1);
    bus.call_req = '0;
    tick(); exp_out("t2_retarget4", 4, 'h090, 1, 0, 1);
    bus.current_floor = 4'd4;
    bus.car_idle = 1'b1;
    tick(); exp_out("t2_arrive4", 4, 'h080, 1, 1, 1);
    dwell3("t2_dwell4", 4, 'h080, 1);
    tick(); exp_out("t2_resume7", 7, 'h080, 1, 0, 1);
    bus.current_floor = 4'd7;
    tick(); exp_out("t2_arrive7", 7, 0, 1, 1, 1);
    dwell3("t2_dwell7", 7, 0, 1);
    tick(); exp_out("t2_idle", 7, 0, 1, 0, 0);
    bus.current_floor = 4'd4;
    tick(); exp_out("t3_hold", 4, 0, 1, 0, 0);
    bus.call_req = 9'h042;
    tick(); exp_out("t3_latch", 4, 'h042, 1, 0, 0);
    bus.call_req = '0;
    tick(); exp_out("t3_nearer6", 6, 'h042, 1, 0, 1);
    bus.current_floor = 4'd6;
    tick(); exp_out("t3_arrive6", 6, 'h002, 1, 1, 1);
    dwell3("t3_dwell6", 6, 'h002, 1);
    tick(); exp_out("t3_flip", 1, 'h002, 0, 0, 1);
    bus.current_floor = 4'd1;
    tick(); exp_out("t3_arrive1", 1, 0, 0, 1, 1);
    dwell3("t3_dwell1", 1, 0, 0);
    tick(); exp_out("t3_idle", 1, 0, 0, 0, 0);
    bus.current_floor = 4'd4;
    tick(); exp_out("tie_hold", 4, 0, 0, 0, 0);
    bus.call_req = 9'h044;
    tick(); exp_out("tie_latch", 4, 'h044, 0, 0, 0);
    bus.call_req = '0;
    tick(); exp_out("tie_up", 6, 'h044, 1, 0, 1);
    bus.call_req = 9'h1A0;
    tick(); exp_out("rst_pre", 6, 'h1E4, 1, 0, 1);
    rst = 1'b1;
    tick(); exp_out("rst_mid", 0, 0, 1, 0, 0);
    rst = 1'b0;
    bus.current_floor = 4'd3;
    bus.call_req = 9'h008;
    tick(); exp_out("t4_open", 3, 0, 1, 1, 1);
    bus.call_req = '0;
    tick(); exp_out("t4_cnt2", 3, 0, 1, 1, 1);
    tick(); exp_out("t4_cnt1", 3, 0, 1, 1, 1);
    bus.call_req = 9'h008;
    tick(); exp_out("t4_reopen", 3, 0, 1, 1, 1);
    bus.call_req = '0;
    dwell3("t4_dwell", 3, 0, 1);
    tick(); exp_out("t4_close", 3, 0, 1, 0, 0);
    bus.call_req = 9'h040;
    tick(); exp_out("t5_latch", 3, 'h040, 1, 0, 0);
    bus.call_req = '0;
    tick(); exp_out("t5_up", 6, 'h040, 1, 0, 1);
    bus.current_floor = 4'd6;
    bus.call_req = 9'h040;
    tick(); exp_out("t5_clear_wins", 6, 0, 1, 1, 1);
    bus.call_req = '0;
    dwell3("t5_dwell", 6, 0, 1);
    tick(); exp_out("t5_idle", 6, 0, 1, 0, 0);
    bus.current_floor = 4'd12;
    bus.call_req = 9'h004;
    tick(); exp_out("t6_oor", 0, 'h004, 1, 0, 0);
    bus.call_req = '0;
    tick(); exp_out("t6_oor_hold", 0, 'h004, 1, 0, 0);
    bus.current_floor = 4'd2;
    tick(); exp_out("t6_serve2", 2, 0, 1, 1, 1);
    dwell3("t6_dwell", 2, 0, 1);
    tick(); exp_out("t6_idle", 2, 0, 1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
